// File: rtl/simple_cpu_pkg.sv
// Shared definitions for the simple HLSCore processor: widths, opcodes,
// instruction field positions, run/halt state and the immediate extender.
package simple_cpu_pkg;

  localparam int DATA_W = 32;
  localparam int NREGS  = 16;
  localparam int REG_AW = 4;

  // Opcodes, instruction bits [31:28]
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_SRL  = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_LUI  = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_ST   = 4'hC;
  localparam logic [3:0] OP_BEQ  = 4'hD;
  localparam logic [3:0] OP_BNE  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Instruction field bit positions
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 28;
  localparam int RD_HI  = 27;
  localparam int RD_LO  = 24;
  localparam int RS1_HI = 23;
  localparam int RS1_LO = 20;
  localparam int RS2_HI = 19;
  localparam int RS2_LO = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // Core run state: running, or parked on a HALT until the next reset
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } cpuState_e;

  // Sign-extend a 16-bit immediate to the datapath width
  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] imm);
    return {{(DATA_W-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/simple_datapath_if.sv
// Instruction- and data-memory bus between the core (master) and the
// memories (slave). Both memories answer combinationally in the same cycle.
interface simple_datapath_if;
  import simple_cpu_pkg::*;

  logic              instMem_rd;
  logic [DATA_W-1:0] instMem_addr;
  logic [DATA_W-1:0] instMem_data;
  logic              dataMem_rd;
  logic              dataMem_wr;
  logic [DATA_W-1:0] dataMem_addr;
  logic [DATA_W-1:0] dataMem_din;
  logic [DATA_W-1:0] dataMem_dout;

  modport master (
    output instMem_rd, instMem_addr,
    input  instMem_data,
    output dataMem_rd, dataMem_wr, dataMem_addr, dataMem_dout,
    input  dataMem_din
  );

  modport slave (
    input  instMem_rd, instMem_addr,
    output instMem_data,
    input  dataMem_rd, dataMem_wr, dataMem_addr, dataMem_dout,
    output dataMem_din
  );

endinterface

// File: rtl/simple_regfile.sv
// 16x32 register file: two combinational read ports, one write port that
// takes effect on the rising edge. r0 always reads as zero.
module simple_regfile
  import simple_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rdAddrA,
  input  logic [REG_AW-1:0] rdAddrB,
  output logic [DATA_W-1:0] rdDataA,
  output logic [DATA_W-1:0] rdDataB,
  input  logic              wrEn,
  input  logic [REG_AW-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData
);

  logic [DATA_W-1:0] regsR [NREGS];

  // Register storage: cleared on reset, writes to r0 are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regsR[i] <= {DATA_W{1'b0}};
      end
    end else if (wrEn && (wrAddr != {REG_AW{1'b0}})) begin
      regsR[wrAddr] <= wrData;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded
  assign rdDataA = (rdAddrA == {REG_AW{1'b0}}) ? {DATA_W{1'b0}} : regsR[rdAddrA];
  assign rdDataB = (rdAddrB == {REG_AW{1'b0}}) ? {DATA_W{1'b0}} : regsR[rdAddrB];

endmodule

// File: rtl/simple_datapath.sv
// Single-cycle core: fetch, decode, execute, memory access and PC update
// all complete in one clock. Decode, ALU and branch logic live here.
module simple_datapath
  import simple_cpu_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  simple_datapath_if.master  bus
);

  logic [DATA_W-1:0] pcR;
  cpuState_e         stateR;
  cpuState_e         stateNextS;

  logic [3:0]        opS;
  logic [REG_AW-1:0] rdS;
  logic [REG_AW-1:0] rs1S;
  logic [REG_AW-1:0] rs2S;
  logic [15:0]       immS;
  logic [DATA_W-1:0] immExtS;
  logic [DATA_W-1:0] rs1ValS;
  logic [DATA_W-1:0] rs2ValS;
  logic [DATA_W-1:0] aluS;
  logic [DATA_W-1:0] memAddrS;
  logic [DATA_W-1:0] pcPlus4S;
  logic [DATA_W-1:0] nextPcS;
  logic              regWeS;
  logic              isLdS;
  logic              isStS;
  logic              takenS;
  logic              haltS;
  logic              activeS;

  assign opS      = bus.instMem_data[OP_HI:OP_LO];
  assign rdS      = bus.instMem_data[RD_HI:RD_LO];
  assign rs1S     = bus.instMem_data[RS1_HI:RS1_LO];
  assign rs2S     = bus.instMem_data[RS2_HI:RS2_LO];
  assign immS     = bus.instMem_data[IMM_HI:IMM_LO];
  assign immExtS  = sext16(immS);
  assign memAddrS = rs1ValS + immExtS;
  assign pcPlus4S = pcR + 32'd4;

  // The core does anything only out of reset and before a HALT
  assign activeS = !reset && (stateR == ST_RUN);

  simple_regfile uRegfile (
    .clk     (clk),
    .reset   (reset),
    .rdAddrA (rs1S),
    .rdAddrB (rs2S),
    .rdDataA (rs1ValS),
    .rdDataB (rs2ValS),
    .wrEn    (regWeS && activeS),
    .wrAddr  (rdS),
    .wrData  (aluS)
  );

  // Decode and ALU: result, write enable, memory intent, branch decision
  always_comb begin
    aluS   = {DATA_W{1'b0}};
    regWeS = 1'b0;
    isLdS  = 1'b0;
    isStS  = 1'b0;
    takenS = 1'b0;
    haltS  = 1'b0;
    case (opS)
      OP_NOP:  aluS = {DATA_W{1'b0}};
      OP_ADD:  begin aluS = rs1ValS + rs2ValS;   regWeS = 1'b1; end
      OP_SUB:  begin aluS = rs1ValS - rs2ValS;   regWeS = 1'b1; end
      OP_AND:  begin aluS = rs1ValS & rs2ValS;   regWeS = 1'b1; end
      OP_OR:   begin aluS = rs1ValS | rs2ValS;   regWeS = 1'b1; end
      OP_XOR:  begin aluS = rs1ValS ^ rs2ValS;   regWeS = 1'b1; end
      OP_SLT:  begin
        aluS   = {{(DATA_W-1){1'b0}}, ($signed(rs1ValS) < $signed(rs2ValS))};
        regWeS = 1'b1;
      end
      OP_SLL:  begin aluS = rs1ValS << rs2ValS[4:0]; regWeS = 1'b1; end
      OP_SRL:  begin aluS = rs1ValS >> rs2ValS[4:0]; regWeS = 1'b1; end
      OP_ADDI: begin aluS = memAddrS;            regWeS = 1'b1; end
      OP_LUI:  begin aluS = {immS, 16'h0000};    regWeS = 1'b1; end
      OP_LD:   begin aluS = bus.dataMem_din;     regWeS = 1'b1; isLdS = 1'b1; end
      OP_ST:   isStS  = 1'b1;
      OP_BEQ:  takenS = (rs1ValS == rs2ValS);
      OP_BNE:  takenS = (rs1ValS != rs2ValS);
      OP_HALT: haltS  = 1'b1;
      default: aluS   = {DATA_W{1'b0}};
    endcase
  end

  // Next PC: sequential, or branch target relative to PC+4 in words
  always_comb begin
    nextPcS = pcPlus4S;
    if (takenS) begin
      nextPcS = pcPlus4S + {immExtS[DATA_W-3:0], 2'b00};
    end else begin
      nextPcS = pcPlus4S;
    end
  end

  // Run/halt next state: HALT parks the core until reset
  always_comb begin
    stateNextS = stateR;
    case (stateR)
      ST_RUN: begin
        if (haltS) begin
          stateNextS = ST_HALT;
        end else begin
          stateNextS = ST_RUN;
        end
      end
      ST_HALT: stateNextS = ST_HALT;
      default: stateNextS = ST_RUN;
    endcase
  end

  // Run/halt state register
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR <= ST_RUN;
    end else begin
      stateR <= stateNextS;
    end
  end

  // PC register: frozen on the HALT address once halted
  always_ff @(posedge clk) begin
    if (reset) begin
      pcR <= RESET_PC;
    end else if (activeS && !haltS) begin
      pcR <= nextPcS;
    end
  end

  assign bus.instMem_rd   = activeS;
  assign bus.instMem_addr = pcR;
  assign bus.dataMem_rd   = activeS && isLdS;
  assign bus.dataMem_wr   = activeS && isStS;
  assign bus.dataMem_addr = (activeS && (isLdS || isStS)) ? memAddrS : {DATA_W{1'b0}};
  assign bus.dataMem_dout = (activeS && isStS) ? rs2ValS : {DATA_W{1'b0}};

endmodule

// File: tb/tb_simple_datapath.sv
// Directed bench for simple_datapath: small instruction ROM and data RAM
// models, hand-computed PC trace and expected memory-bus activity.
module tb_simple_datapath;
  import simple_cpu_pkg::*;

  typedef struct packed {
    logic [1:0]  strb;   // {rd, wr}
    logic [31:0] addr;
    logic [31:0] dout;
  } memExp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] rom  [64];
  logic [31:0] dmem [128];

  simple_datapath_if bus ();

  simple_datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.instMem_data = rom[bus.instMem_addr[7:2]];
  assign bus.dataMem_din  = dmem[bus.dataMem_addr[8:2]];

  // Data memory write port
  always @(posedge clk) begin
    if (bus.dataMem_wr) dmem[bus.dataMem_addr[8:2]] <= bus.dataMem_dout;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic clearRom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0000;
  endtask

  task automatic loadPhase1();
    clearRom();
    rom[0]  = 32'h9100_0005; // ADDI r1,r0,5
    rom[1]  = 32'h9200_FFFD; // ADDI r2,r0,-3
    rom[2]  = 32'h1312_0000; // ADD  r3,r1,r2
    rom[3]  = 32'h2421_0000; // SUB  r4,r2,r1
    rom[4]  = 32'hC003_0000; // ST   r3,0(r0)
    rom[5]  = 32'hC004_0004; // ST   r4,4(r0)
    rom[6]  = 32'h9000_0007; // ADDI r0,r0,7
    rom[7]  = 32'h1600_0000; // ADD  r6,r0,r0
    rom[8]  = 32'hC006_0008; // ST   r6,8(r0)
    rom[9]  = 32'h9800_FFFF; // ADDI r8,r0,-1
    rom[10] = 32'h9900_0001; // ADDI r9,r0,1
    rom[11] = 32'h6789_0000; // SLT  r7,r8,r9
    rom[12] = 32'hC007_000C; // ST   r7,12(r0)
    rom[13] = 32'h9100_0100; // ADDI r1,r0,0x100
    rom[14] = 32'hA200_DEAE; // LUI  r2,0xDEAE
    rom[15] = 32'h9220_BEEF; // ADDI r2,r2,0xBEEF -> 0xDEADBEEF
    rom[16] = 32'hC012_0008; // ST   r2,8(r1)
    rom[17] = 32'hB510_0008; // LD   r5,8(r1)
    rom[18] = 32'hC005_0010; // ST   r5,0x10(r0)
    rom[19] = 32'h7A29_0000; // SLL  r10,r2,r9
    rom[20] = 32'h8B29_0000; // SRL  r11,r2,r9
    rom[21] = 32'hC00A_0014; // ST   r10,0x14(r0)
    rom[22] = 32'hC00B_0018; // ST   r11,0x18(r0)
    rom[23] = 32'h3C24_0000; // AND  r12,r2,r4
    rom[24] = 32'h4D13_0000; // OR   r13,r1,r3
    rom[25] = 32'h5E19_0000; // XOR  r14,r1,r9
    rom[26] = 32'hC00C_001C; // ST   r12,0x1C(r0)
    rom[27] = 32'hC00D_0020; // ST   r13,0x20(r0)
    rom[28] = 32'hC00E_0024; // ST   r14,0x24(r0)
    rom[29] = 32'hE011_0004; // 0x74 BNE r1,r1,+4 (not taken)
    rom[30] = 32'hE019_0001; // 0x78 BNE r1,r9,+1 -> 0x80
    rom[31] = 32'hC001_0000; // 0x7C ST r1 (must be skipped)
    rom[32] = 32'hD011_FFFF; // 0x80 BEQ r1,r1,-1 (self loop)
  endtask

  task automatic loadPhase2();
    clearRom();
    rom[0]  = 32'hC002_0000; // ST r2,0(r0)  - regs cleared by reset
    rom[1]  = 32'hC005_0004; // ST r5,4(r0)
    rom[12] = 32'hF000_0000; // 0x30 HALT
    rom[13] = 32'hC001_0000; // 0x34 ST r1 (must never run)
  endtask

  function automatic memExp_t expMem(input int phase, input logic [31:0] pc);
    memExp_t e;
    e = '{strb: 2'b00, addr: 32'h0, dout: 32'h0};
    if (phase == 1) begin
      case (pc)
        32'h10: e = '{2'b01, 32'h0000_0000, 32'h0000_0002};
        32'h14: e = '{2'b01, 32'h0000_0004, 32'hFFFF_FFF8};
        32'h20: e = '{2'b01, 32'h0000_0008, 32'h0000_0000};
        32'h30: e = '{2'b01, 32'h0000_000C, 32'h0000_0001};
        32'h40: e = '{2'b01, 32'h0000_0108, 32'hDEAD_BEEF};
        32'h44: e = '{2'b10, 32'h0000_0108, 32'h0000_0000};
        32'h48: e = '{2'b01, 32'h0000_0010, 32'hDEAD_BEEF};
        32'h54: e = '{2'b01, 32'h0000_0014, 32'hBD5B_7DDE};
        32'h58: e = '{2'b01, 32'h0000_0018, 32'h6F56_DF77};
        32'h68: e = '{2'b01, 32'h0000_001C, 32'hDEAD_BEE8};
        32'h6C: e = '{2'b01, 32'h0000_0020, 32'h0000_0102};
        32'h70: e = '{2'b01, 32'h0000_0024, 32'h0000_0101};
        default: e = '{2'b00, 32'h0, 32'h0};
      endcase
    end else begin
      case (pc)
        32'h00: e = '{2'b01, 32'h0000_0000, 32'h0000_0000};
        32'h04: e = '{2'b01, 32'h0000_0004, 32'h0000_0000};
        default: e = '{2'b00, 32'h0, 32'h0};
      endcase
    end
    return e;
  endfunction

  task automatic chkMem(input memExp_t e);
    chk("dm_strb", {30'd0, bus.dataMem_rd, bus.dataMem_wr}, {30'd0, e.strb});
    chk("dm_addr", bus.dataMem_addr, e.addr);
    chk("dm_dout", bus.dataMem_dout, e.dout);
  endtask

  task automatic chkQuiet(input string tag);
    chk({tag, "_imrd"}, {31'd0, bus.instMem_rd}, 32'd0);
    chk({tag, "_strb"}, {30'd0, bus.dataMem_rd, bus.dataMem_wr}, 32'd0);
    chk({tag, "_addr"}, bus.dataMem_addr, 32'd0);
    chk({tag, "_dout"}, bus.dataMem_dout, 32'd0);
  endtask

  initial begin
    logic [31:0] expPc;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    for (int i = 0; i < 128; i++) dmem[i] = 32'h0;
    loadPhase1();

    // Held in reset for 100 ns: everything quiet
    repeat (5) @(negedge clk);
    #1 chkQuiet("rst");
    repeat (5) @(negedge clk);
    reset = 1'b0;

    // Phase 1: ALU, r0, SLT, load/store, branches, self loop
    expPc = 32'h0;
    for (int s = 0; s < 34; s++) begin
      #1;
      chk("p1_pc", bus.instMem_addr, expPc);
      chk("p1_imrd", {31'd0, bus.instMem_rd}, 32'd1);
      chkMem(expMem(1, expPc));
      @(negedge clk);
      if (expPc == 32'h78) expPc = 32'h80;
      else if (expPc != 32'h80) expPc = expPc + 32'd4;
    end
    chk("p1_dmem108", dmem[66], 32'hDEAD_BEEF);

    // Reset mid-run: strobes gated immediately, PC back to 0 after the edge
    reset = 1'b1;
    loadPhase2();
    #1 chkQuiet("midrst");
    @(negedge clk);
    #1;
    chk("midrst_pc", bus.instMem_addr, 32'h0);
    chkQuiet("midrst2");
    @(negedge clk);
    reset = 1'b0;

    // Phase 2: registers read back as zero, then HALT at 0x30 freezes the core
    for (int s = 0; s < 17; s++) begin
      #1;
      expPc = (s <= 12) ? (32'(s) * 32'd4) : 32'h30;
      chk("p2_pc", bus.instMem_addr, expPc);
      chk("p2_imrd", {31'd0, bus.instMem_rd}, (s <= 12) ? 32'd1 : 32'd0);
      chkMem(expMem(2, expPc));
      @(negedge clk);
    end

    // Reset releases the halt
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_pc", bus.instMem_addr, 32'h0);
    chk("rel_imrd", {31'd0, bus.instMem_rd}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
